// File: rtl/decimal_entry_to_twelve_four_fixed_pkg.sv
// decimal_entry_to_twelve_four_fixed_pkg: shared states and constants for the decimal-entry to 12.4 converter
package decimal_entry_to_twelve_four_fixed_pkg;
  typedef enum logic [2:0] {INT, FRAC, PAD, CONV, DONE} state_e;
  localparam int FRAC_BITS = 4;
  localparam int DEC_SCALE = 10000;
  localparam logic [15:0] POS_MAX = 16'h7FFF;
  localparam logic [16:0] NEG_MAX_MAG = 17'h08000;
endpackage

// File: rtl/decimal_entry_to_twelve_four_fixed_frac_dec_to_bin.sv
// decimal_entry_to_twelve_four_fixed_frac_dec_to_bin: 4-bit binary fraction plus round bit from a 0..9999 decimal fraction
// Ports: clk, rst (sync, active-low), start (held high for the 5 extraction cycles),
//   frac_acc (scaled fraction, sampled on the first cycle), frac_bits/round (results), done (last cycle).
module decimal_entry_to_twelve_four_fixed_frac_dec_to_bin
  import decimal_entry_to_twelve_four_fixed_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [13:0]          frac_acc,
  output logic [FRAC_BITS-1:0] frac_bits,
  output logic                 round,
  output logic                 done
);
  logic [2:0] cnt_q, cnt_d;
  logic [14:0] r_q, r_d, src, sh;
  logic [FRAC_BITS-1:0] bits_q, bits_d;
  logic round_q, round_d, ge;
  // Cycle 0 takes the fresh fraction; later cycles continue from the remainder.
  assign src = cnt_q == 3'd0 ? {1'b0, frac_acc} : r_q;
  assign sh = {src[13:0], 1'b0};
  assign ge = sh >= 15'(DEC_SCALE);
  always_comb begin
    cnt_d = !start || cnt_q == 3'd4 ? 3'd0 : cnt_q + 3'd1;
    r_d = start && cnt_q < 3'd4 ? (ge ? sh - 15'(DEC_SCALE) : sh) : r_q;
    bits_d = start && cnt_q < 3'd4 ? {bits_q[FRAC_BITS-2:0], ge} : bits_q;
    round_d = start && cnt_q == 3'd4 ? {r_q, 1'b0} >= 16'(DEC_SCALE) : round_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      r_q <= '0;
      bits_q <= '0;
      round_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      r_q <= r_d;
      bits_q <= bits_d;
      round_q <= round_d;
    end
  end
  assign frac_bits = bits_q;
  assign round = round_q;
  assign done = start && cnt_q == 3'd4;
endmodule

// File: rtl/decimal_entry_to_twelve_four_fixed.sv
// decimal_entry_to_twelve_four_fixed: keypad decimal entry to signed 12.4 fixed point with rounding and saturation
// Ports: clk, rst (sync, active-low); key_valid qualifies key_digit/key_is_digit/key_point/key_neg/key_enter/key_clear;
//   val/overflow hold the last result, val_valid pulses on update, busy during conversion,
//   entry_neg/in_frac reflect the entry in progress.
module decimal_entry_to_twelve_four_fixed
  import decimal_entry_to_twelve_four_fixed_pkg::*;
#(
  parameter int MAX_INT_DIGITS = 4,
  parameter int FRAC_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_is_digit,
  input  logic        key_point,
  input  logic        key_neg,
  input  logic        key_enter,
  input  logic        key_clear,
  output logic [15:0] val,
  output logic        val_valid,
  output logic        overflow,
  output logic        busy,
  output logic        entry_neg,
  output logic        in_frac
);
  state_e state_q, state_d;
  logic [13:0] int_acc_q, int_acc_d, frac_acc_q, frac_acc_d;
  logic [2:0] int_cnt_q, int_cnt_d, frac_cnt_q, frac_cnt_d;
  logic [1:0] pcnt_q, pcnt_d;
  logic neg_q, neg_d, in_frac_q, in_frac_d, vv_q, vv_d, ovf_q, ovf_d;
  logic [15:0] val_q, val_d;
  logic [FRAC_BITS-1:0] frac_bits;
  logic round, conv_done;
  logic [17:0] mag;
  decimal_entry_to_twelve_four_fixed_frac_dec_to_bin u_fdb (
    .clk(clk), .rst(rst), .start(state_q == CONV), .frac_acc(frac_acc_q),
    .frac_bits(frac_bits), .round(round), .done(conv_done)
  );
  // Widened past 17 bits so a 4-digit integer part cannot wrap before saturation.
  assign mag = {int_acc_q, frac_bits} + 18'(round);
  always_comb begin
    state_d = state_q;
    int_acc_d = int_acc_q;
    frac_acc_d = frac_acc_q;
    int_cnt_d = int_cnt_q;
    frac_cnt_d = frac_cnt_q;
    pcnt_d = pcnt_q;
    neg_d = neg_q;
    in_frac_d = in_frac_q;
    val_d = val_q;
    ovf_d = ovf_q;
    vv_d = 1'b0;
    case (state_q)
      INT, FRAC: if (key_valid) begin
        if (key_clear) begin
          state_d = INT;
          {int_acc_d, frac_acc_d, int_cnt_d, frac_cnt_d} = '0;
          neg_d = 1'b0;
          in_frac_d = 1'b0;
        end else if (key_enter) begin
          state_d = PAD;
          pcnt_d = 2'd0;
        end else if (key_point) begin
          state_d = FRAC;
          in_frac_d = 1'b1;
        end else if (key_neg) neg_d = ~neg_q;
        else if (key_is_digit && key_digit <= 4'd9) begin
          if (state_q == INT && int_cnt_q < 3'(MAX_INT_DIGITS)) begin
            int_acc_d = 14'(int_acc_q * 14'd10 + 14'(key_digit));
            int_cnt_d = int_cnt_q + 3'd1;
          end else if (state_q == FRAC && frac_cnt_q < 3'(FRAC_DIGITS)) begin
            frac_acc_d = 14'(frac_acc_q * 14'd10 + 14'(key_digit));
            frac_cnt_d = frac_cnt_q + 3'd1;
          end
        end
      end
      PAD: begin
        // Append the missing trailing zeros so the fraction is in units of 1/10000.
        if ({1'b0, pcnt_q} < 3'(FRAC_DIGITS) - frac_cnt_q) frac_acc_d = 14'(frac_acc_q * 14'd10);
        pcnt_d = pcnt_q + 2'd1;
        if (pcnt_q == 2'd3) state_d = CONV;
      end
      CONV: if (conv_done) state_d = DONE;
      default: begin
        ovf_d = neg_q ? mag > 18'(NEG_MAX_MAG) : mag > 18'(POS_MAX);
        val_d = neg_q ? (ovf_d ? 16'h8000 : 16'(-mag)) : (ovf_d ? POS_MAX : mag[15:0]);
        vv_d = 1'b1;
        {int_acc_d, frac_acc_d, int_cnt_d, frac_cnt_d} = '0;
        neg_d = 1'b0;
        in_frac_d = 1'b0;
        state_d = INT;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INT;
      {int_acc_q, frac_acc_q, int_cnt_q, frac_cnt_q, pcnt_q} <= '0;
      {neg_q, in_frac_q, vv_q, ovf_q} <= '0;
      val_q <= '0;
    end else begin
      state_q <= state_d;
      int_acc_q <= int_acc_d;
      frac_acc_q <= frac_acc_d;
      int_cnt_q <= int_cnt_d;
      frac_cnt_q <= frac_cnt_d;
      pcnt_q <= pcnt_d;
      neg_q <= neg_d;
      in_frac_q <= in_frac_d;
      vv_q <= vv_d;
      ovf_q <= ovf_d;
      val_q <= val_d;
    end
  end
  assign val = val_q;
  assign val_valid = vv_q;
  assign overflow = ovf_q;
  assign busy = state_q == PAD || state_q == CONV || state_q == DONE;
  assign entry_neg = neg_q;
  assign in_frac = in_frac_q;
endmodule

// File: tb/tb_decimal_entry_to_twelve_four_fixed.sv
// tb_decimal_entry_to_twelve_four_fixed: directed checks of decimal entry to 12.4 conversion
module tb_decimal_entry_to_twelve_four_fixed;
  logic clk = 1'b0, rst = 1'b0;
  logic key_valid = 1'b0, key_is_digit = 1'b0, key_point = 1'b0, key_neg = 1'b0, key_enter = 1'b0, key_clear = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic [15:0] val;
  logic val_valid, overflow, busy, entry_neg, in_frac;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  decimal_entry_to_twelve_four_fixed dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit), .key_is_digit(key_is_digit),
    .key_point(key_point), .key_neg(key_neg), .key_enter(key_enter), .key_clear(key_clear),
    .val(val), .val_valid(val_valid), .overflow(overflow), .busy(busy), .entry_neg(entry_neg), .in_frac(in_frac)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {key_valid, key_is_digit, key_point, key_neg, key_enter, key_clear} = '0;
    key_digit = 4'd0;
  endtask
  task automatic dig(input logic [3:0] d);
    @(negedge clk); key_valid = 1'b1; key_is_digit = 1'b1; key_digit = d;
    @(negedge clk); idle();
  endtask
  task automatic pt();
    @(negedge clk); key_valid = 1'b1; key_point = 1'b1;
    @(negedge clk); idle();
  endtask
  task automatic ng();
    @(negedge clk); key_valid = 1'b1; key_neg = 1'b1;
    @(negedge clk); idle();
  endtask
  task automatic conv(input string tag, input logic [15:0] ev, input logic eo, input bit junk);
    int seen = 0;
    @(negedge clk); key_valid = 1'b1; key_enter = 1'b1;
    @(negedge clk); idle();
    check({tag, " busy"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      if (junk && i < 9) begin
        key_valid = 1'b1; key_clear = i[0]; key_neg = ~i[0]; key_point = 1'b1; key_is_digit = 1'b1; key_digit = 4'd9;
      end
      @(negedge clk); idle();
      if (val_valid) seen = i;
    end
    check({tag, " latency"}, 32'(seen), 32'd10);
    check({tag, " val"}, 32'(val), 32'(ev));
    check({tag, " ovf"}, 32'(overflow), 32'(eo));
    @(negedge clk);
    check({tag, " pulse"}, 32'(val_valid), 32'd0);
    check({tag, " idle"}, {29'd0, busy, entry_neg, in_frac}, 32'd0);
    check({tag, " held"}, {15'd0, overflow, val}, {15'd0, eo, ev});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int vv_seen;
    repeat (3) @(negedge clk);
    check("reset", {26'd0, val_valid, overflow, busy, entry_neg, in_frac, 1'b0, val != 16'd0}, 32'd0);
    rst = 1'b1;
    dig(1); pt(); dig(5);
    check("in_frac set", 32'(in_frac), 32'd1);
    conv("1.5", 16'h0018, 1'b0, 1'b0);
    dig(3); pt(); dig(1); dig(4);
    conv("3.14", 16'h0032, 1'b0, 1'b0);
    ng(); dig(2); pt(); dig(5);
    check("entry_neg set", 32'(entry_neg), 32'd1);
    conv("-2.5", 16'hFFD8, 1'b0, 1'b0);
    ng(); dig(2); dig(0); dig(4); dig(8);
    conv("-2048", 16'h8000, 1'b0, 1'b0);
    pt(); dig(0); dig(3); dig(1); dig(3);
    conv("0.0313", 16'h0001, 1'b0, 1'b0);
    pt(); dig(0); dig(3);
    conv("0.03", 16'h0000, 1'b0, 1'b0);
    pt(); dig(9); dig(9); dig(9); dig(9);
    conv("0.9999", 16'h0010, 1'b0, 1'b0);
    dig(2); dig(0); dig(4); dig(7); pt(); dig(9); dig(9); dig(9); dig(9);
    conv("2047.9999", 16'h7FFF, 1'b1, 1'b0);
    dig(1); dig(2); dig(3); dig(4); dig(5);
    conv("5th digit", 16'h4D20, 1'b0, 1'b0);
    conv("empty", 16'h0000, 1'b0, 1'b0);
    ng(); dig(7); pt(); dig(3);
    @(negedge clk); key_valid = 1'b1; key_clear = 1'b1; key_is_digit = 1'b1; key_digit = 4'd5;
    @(negedge clk); idle();
    check("clear state", {30'd0, entry_neg, in_frac}, 32'd0);
    check("clear keeps val", 32'(val), 32'h0000);
    dig(2);
    conv("after clear", 16'h0020, 1'b0, 1'b0);
    dig(1);
    conv("busy keys", 16'h0010, 1'b0, 1'b1);
    ng(); dig(9); dig(9); dig(9); dig(9);
    conv("-9999", 16'h8000, 1'b1, 1'b0);
    dig(5);
    @(negedge clk); key_valid = 1'b1; key_enter = 1'b1;
    @(negedge clk); idle();
    repeat (5) @(negedge clk);
    check("mid conv busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check("abort state", {15'd0, overflow, val}, 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    vv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (val_valid) vv_seen++;
    end
    check("abort no valid", 32'(vv_seen), 32'd0);
    dig(3);
    conv("after abort", 16'h0030, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
